// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S receiver: receive FSM states and the
// widest supported sample word.
package i2s_pkg;

    localparam int I2S_MAX_W = 32;
    // Bit counter must be able to hold I2S_MAX_W (saturation value).
    localparam int I2S_CNT_W = $clog2(I2S_MAX_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } rx_state_t;

endpackage

// File: rtl/i2s_sync_edge.sv
// Brings the asynchronous I2S serial clock, word select and data into the
// system clock domain and flags the cycle in which a synced SCK rise is seen.
// All three lines share the same depth so ws/td line up with the SCK edge.
module i2s_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic tclk_i,
    input  logic ws_i,
    input  logic td_i,
    output logic ws_o,
    output logic td_o,
    output logic rise_o
);

    logic [STAGES-1:0] tclk_q, ws_q, td_q;
    logic              tclk_prev_q;

    // Synchronizer chains plus the previous synced SCK for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tclk_q      <= '0;
            ws_q        <= '0;
            td_q        <= '0;
            tclk_prev_q <= 1'b0;
        end else begin
            tclk_q      <= {tclk_q[STAGES-2:0], tclk_i};
            ws_q        <= {ws_q[STAGES-2:0], ws_i};
            td_q        <= {td_q[STAGES-2:0], td_i};
            tclk_prev_q <= tclk_q[STAGES-1];
        end
    end

    assign ws_o   = ws_q[STAGES-1];
    assign td_o   = td_q[STAGES-1];
    assign rise_o = tclk_q[STAGES-1] & ~tclk_prev_q;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: aligns to the left/right frame, deserialises MSB-first
// words and presents complete left/right pairs on a valid/ready port.
// Optional feature macro I2S_RX_OVERRUN_EN: sticky o_overrun flag for
// pairs dropped while the consumer is stalled (tied low otherwise).
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic              i_tclk,
    input  logic              i_ws,
    input  logic              i_td,
    output logic [DATA_W-1:0] o_data_left,
    output logic [DATA_W-1:0] o_data_right,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_locked,
    output logic              o_overrun,
    input  logic              i_ovr_clr
);

    rx_state_t            state_q, state_d;
    logic                 ws_s, td_s, bit_edge;
    logic                 ws_d_q;
    logic [I2S_CNT_W-1:0] cnt_q;
    logic [DATA_W-1:0]    sr_q, word;
    logic [DATA_W-1:0]    hold_q;
    logic [DATA_W-1:0]    data_l_q, data_r_q;
    logic                 valid_q;
    logic                 word_end, left_done, pair_done, drop;

    i2s_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i  (i_clk),
        .rst_ni (i_rst_n),
        .tclk_i (i_tclk),
        .ws_i   (i_ws),
        .td_i   (i_td),
        .ws_o   (ws_s),
        .td_o   (td_s),
        .rise_o (bit_edge)
    );

    // A ws change at a bit edge means the bit just sampled is the LSB of
    // the word belonging to the previous ws value.
    assign word_end = bit_edge && (ws_s != ws_d_q);

    // Current word with the bit at this edge merged in; bits past DATA_W
    // never match the counter and are discarded.
    always_comb begin
        word = sr_q;
        for (int i = 0; i < DATA_W; i++) begin
            if (cnt_q == I2S_CNT_W'(DATA_W - 1 - i)) word[i] = td_s;
        end
    end

    // Next-state and word-completion strobes.
    always_comb begin
        state_d   = state_q;
        left_done = 1'b0;
        pair_done = 1'b0;
        if (!i_enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  state_d = SYNC;
                SYNC:  if (bit_edge && ws_d_q && !ws_s) state_d = LEFT;
                LEFT:  if (bit_edge && !ws_d_q && ws_s) begin
                           state_d   = RIGHT;
                           left_done = 1'b1;
                       end
                RIGHT: if (bit_edge && ws_d_q && !ws_s) begin
                           state_d   = LEFT;
                           pair_done = 1'b1;
                       end
                default: state_d = IDLE;
            endcase
        end
    end

    // A pair arriving while the presented one is still stalled is lost.
    assign drop = pair_done && valid_q && !i_ready;

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Bit capture: ws history, bit counter, shift register, held left word.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ws_d_q <= 1'b0;
            cnt_q  <= '0;
            sr_q   <= '0;
            hold_q <= '0;
        end else begin
            if (bit_edge) ws_d_q <= ws_s;
            if (!i_enable || state_q == IDLE) begin
                cnt_q  <= '0;
                sr_q   <= '0;
                hold_q <= '0;
            end else begin
                if (left_done) hold_q <= word;
                if (word_end) begin
                    cnt_q <= '0;
                    sr_q  <= '0;
                end else if (bit_edge) begin
                    sr_q <= word;
                    if (cnt_q < I2S_CNT_W'(DATA_W)) cnt_q <= cnt_q + I2S_CNT_W'(1);
                end
            end
        end
    end

    // Output pair register with valid/ready handshake.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_l_q <= '0;
            data_r_q <= '0;
            valid_q  <= 1'b0;
        end else if (pair_done && (!valid_q || i_ready)) begin
            data_l_q <= hold_q;
            data_r_q <= word;
            valid_q  <= 1'b1;
        end else if (valid_q && i_ready) begin
            valid_q  <= 1'b0;
        end
    end

`ifdef I2S_RX_OVERRUN_EN
    logic ovr_q;

    // Sticky drop flag; a clear wins over a drop in the same cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)       ovr_q <= 1'b0;
        else if (i_ovr_clr) ovr_q <= 1'b0;
        else if (drop)      ovr_q <= 1'b1;
    end

    assign o_overrun = ovr_q;
`else
    logic unused_ovr;
    assign unused_ovr = i_ovr_clr ^ drop;
    assign o_overrun  = 1'b0;
`endif

    assign o_data_left  = data_l_q;
    assign o_data_right = data_r_q;
    assign o_valid      = valid_q;
    assign o_locked     = (state_q == LEFT) || (state_q == RIGHT);

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: a 32-bit and a 24-bit receiver share the same
// serial stream and handshake; expected pairs go into per-DUT queues when a
// frame is driven and are popped when the DUT hands a pair over.
module tb_i2s_rx;

`ifdef I2S_RX_OVERRUN_EN
    localparam logic OVR_EN = 1'b1;
`else
    localparam logic OVR_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
    } pair_t;

    logic        clk = 1'b0;
    logic        rst_n, enable, tclk, ws, td, ready, ovr_clr;
    logic [31:0] a_l, a_r;
    logic [23:0] b_l, b_r;
    logic        a_valid, a_locked, a_ovr;
    logic        b_valid, b_locked, b_ovr;

    int    checks = 0;
    int    errors = 0;
    int    na_seen = 0;
    int    nb_seen = 0;
    pair_t qa[$];
    pair_t qb[$];

    always #5 clk = ~clk;

    i2s_rx #(.DATA_W(32), .SYNC_STAGES(2)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_tclk(tclk),
        .i_ws(ws), .i_td(td), .o_data_left(a_l), .o_data_right(a_r),
        .o_valid(a_valid), .i_ready(ready), .o_locked(a_locked),
        .o_overrun(a_ovr), .i_ovr_clr(ovr_clr)
    );

    i2s_rx #(.DATA_W(24), .SYNC_STAGES(3)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_tclk(tclk),
        .i_ws(ws), .i_td(td), .o_data_left(b_l), .o_data_right(b_r),
        .o_valid(b_valid), .i_ready(ready), .o_locked(b_locked),
        .o_overrun(b_ovr), .i_ovr_clr(ovr_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference capture: first W bits of an S-bit slot, MSB-aligned, zero-padded.
    function automatic logic [31:0] exp_word(input int s, input logic [31:0] v, input int w);
        logic [63:0] m;
        logic [31:0] r;
        m = (64'd1 << w) - 64'd1;
        if (s >= w) r = v >> (s - w);
        else        r = v << (w - s);
        return r & m[31:0];
    endfunction

    task automatic push(input int s, input logic [31:0] l, input logic [31:0] r);
        qa.push_back('{exp_word(s, l, 32), exp_word(s, r, 32)});
        qb.push_back('{exp_word(s, l, 24), exp_word(s, r, 24)});
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One SCK period: lines change with SCK low, receiver samples on the rise.
    task automatic send_bit(input logic w, input logic d);
        tclk = 1'b0; ws = w; td = d;
        clks(4);
        tclk = 1'b1;
        clks(4);
    endtask

    // Bits first..last of one channel slot; ws leads the data by one bit.
    task automatic send_word(input int s, input logic [31:0] v, input logic right,
                             input int first, input int last);
        for (int k = first; k <= last; k++)
            send_bit(right ? (k != s - 1) : (k == s - 1), v[s-1-k]);
    endtask

    task automatic send_frame(input int s, input logic [31:0] l, input logic [31:0] r);
        send_word(s, l, 1'b0, 0, s - 1);
        send_word(s, r, 1'b1, 0, s - 1);
    endtask

    // Scoreboard pop on each handshake.
    always @(negedge clk) begin
        if (rst_n && a_valid && ready) begin
            pair_t e;
            chk("A_pair_expected", 32'(qa.size() != 0), 32'd1);
            if (qa.size() != 0) begin
                e = qa.pop_front();
                chk("A_left", a_l, e.l);
                chk("A_right", a_r, e.r);
            end
            na_seen++;
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_valid && ready) begin
            pair_t e;
            chk("B_pair_expected", 32'(qb.size() != 0), 32'd1);
            if (qb.size() != 0) begin
                e = qb.pop_front();
                chk("B_left", 32'(b_l), e.l);
                chk("B_right", 32'(b_r), e.r);
            end
            nb_seen++;
        end
    end

    initial begin
        logic [31:0] hl, hr, x;
        rst_n = 1'b0; enable = 1'b0; ready = 1'b1; ovr_clr = 1'b0;
        tclk = 1'b0; ws = 1'b0; td = 1'b0;
        clks(3);
        chk("rst_valid", a_valid, 0);
        chk("rst_locked", a_locked, 0);
        chk("rst_overrun", a_ovr, 0);
        chk("rst_left", a_l, 0);
        chk("rst_right", a_r, 0);

        rst_n = 1'b1;
        clks(2);
        enable = 1'b1;
        clks(3);
        chk("sync_not_locked", a_locked, 0);
        // tail of a right word: ws 1->0 on its last bit gives alignment
        send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
        clks(2);
        chk("locked_after_ws_fall", a_locked, 1);
        chk("B_locked", b_locked, 1);

        // basic 32-bit frames, consumer always ready
        push(32, 32'hA5A5_0001, 32'h5A5A_8000);
        send_frame(32, 32'hA5A5_0001, 32'h5A5A_8000);
        clks(3);
        chk("A_valid_pulse_done", a_valid, 0);
        chk("B_valid_pulse_done", b_valid, 0);
        chk("A_first_pair_seen", na_seen, 1);
        for (int f = 0; f < 2; f++) begin
            hl = $urandom; hr = $urandom;
            push(32, hl, hr);
            send_frame(32, hl, hr);
        end

        // truncation with 32-bit slots, zero padding with 16-bit slots
        push(32, 32'h1234_56FF, 32'h0F0F_F0F0);
        send_frame(32, 32'h1234_56FF, 32'h0F0F_F0F0);
        clks(3);
        chk("B_trunc_left", 32'(b_l), 32'h0012_3456);
        push(16, 32'h0000_BEEF, 32'h0000_1234);
        send_frame(16, 32'h0000_BEEF, 32'h0000_1234);
        clks(3);
        chk("B_pad_left", 32'(b_l), 32'h00BE_EF00);
        chk("A_pad_left", a_l, 32'hBEEF_0000);

        // stalled consumer over three frames: first pair held, rest dropped
        ready = 1'b0;
        hl = $urandom; hr = $urandom;
        push(32, hl, hr);
        send_frame(32, hl, hr);
        for (int f = 0; f < 2; f++) begin
            x = $urandom;
            send_frame(32, x, ~x);
        end
        clks(2);
        chk("hold_valid", a_valid, 1);
        chk("hold_left", a_l, hl);
        chk("hold_right", a_r, hr);
        chk("overrun_set", a_ovr, OVR_EN);
        ovr_clr = 1'b1;
        clks(1);
        ovr_clr = 1'b0;
        chk("overrun_cleared", a_ovr, 0);
        ready = 1'b1;
        clks(3);
        chk("held_pair_taken", a_valid, 0);
        chk("A_queue_drained", qa.size(), 0);

        // disable mid-left word, re-enable mid-right word
        x = $urandom;
        send_word(32, x, 1'b0, 0, 9);
        enable = 1'b0;
        clks(1);
        chk("disable_unlocks", a_locked, 0);
        send_word(32, x, 1'b0, 10, 31);
        send_word(32, ~x, 1'b1, 0, 15);
        enable = 1'b1;
        clks(1);
        chk("reenable_sync", a_locked, 0);
        send_word(32, ~x, 1'b1, 16, 31);
        clks(2);
        chk("relocked", a_locked, 1);
        chk("no_spurious_pair", na_seen, 6);
        hl = $urandom; hr = $urandom;
        push(32, hl, hr);
        send_frame(32, hl, hr);
        clks(3);
        chk("A_pairs_total", na_seen, 7);
        chk("B_pairs_total", nb_seen, 7);

        // asynchronous reset while a pair is presented
        ready = 1'b0;
        hl = $urandom; hr = $urandom;
        push(32, hl, hr);
        send_frame(32, hl, hr);
        send_word(32, 32'hFFFF_FFFF, 1'b0, 0, 5);
        chk("pre_reset_valid", a_valid, 1);
        chk("pre_reset_one_pending", qa.size(), 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_valid", a_valid, 0);
        chk("arst_locked", a_locked, 0);
        chk("arst_overrun", a_ovr, 0);
        chk("arst_left", a_l, 0);
        chk("arst_right", a_r, 0);
        chk("arst_B_valid", b_valid, 0);
        qa.delete();
        qb.delete();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
